// File: rtl/lsu_ctrl_pkg.sv
// Shared types and helpers for the load/store unit controller:
// FSM state encoding, funct3 size codes, error codes and lane helpers.
package lsu_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

   // Unsigned sizes exist only for loads.
   function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
      logic res;
      case (f3)
         F3_B, F3_H, F3_W: res = 1'b0;
         F3_BU, F3_HU:     res = we;
         default:          res = 1'b1;
      endcase
      return res;
   endfunction

   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
      logic res;
      case (f3)
         F3_H, F3_HU: res = off[0];
         F3_W:        res = (off != 2'b00);
         default:     res = 1'b0;
      endcase
      return res;
   endfunction

   function automatic logic [3:0] be_gen(input logic we, input logic [2:0] f3, input logic [1:0] off);
      logic [3:0] res;
      if (!we) begin
         res = 4'b0000;
      end else begin
         case (f3)
            F3_B:    res = 4'b0001 << off;
            F3_H:    res = 4'b0011 << off;
            F3_W:    res = 4'b1111;
            default: res = 4'b0000;
         endcase
      end
      return res;
   endfunction

   function automatic logic [31:0] wdata_gen(input logic [2:0] f3, input logic [31:0] wdata);
      logic [31:0] res;
      case (f3)
         F3_B:    res = {4{wdata[7:0]}};
         F3_H:    res = {2{wdata[15:0]}};
         default: res = wdata;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/lsu_ctrl_extract.sv
// Load lane selection and sign/zero extension of the returned memory word.
module lsu_extract
   import lsu_ctrl_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   always_comb begin
      byte_s = 8'h00;
      case (off_i)
         2'b00:   byte_s = rdata_i[7:0];
         2'b01:   byte_s = rdata_i[15:8];
         2'b10:   byte_s = rdata_i[23:16];
         2'b11:   byte_s = rdata_i[31:24];
         default: byte_s = 8'h00;
      endcase
      if (off_i[1]) begin
         half_s = rdata_i[31:16];
      end else begin
         half_s = rdata_i[15:0];
      end
      case (funct3_i)
         F3_B:    data_o = {{24{byte_s[7]}}, byte_s};
         F3_H:    data_o = {{16{half_s[15]}}, half_s};
         F3_W:    data_o = rdata_i;
         F3_BU:   data_o = {24'h000000, byte_s};
         F3_HU:   data_o = {16'h0000, half_s};
         default: data_o = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one memory operation at a time, issues
// a single memory request, waits for read data and reports completion/errors.
module lsu_ctrl
   import lsu_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_valid,
   input  logic        i_we,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   input  logic        i_kill,
   output logic        o_ready,
   output logic        o_done,
   output logic [31:0] o_ld_data,
   output logic [1:0]  o_err,
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   output logic [3:0]  o_mem_be,
   input  logic        i_mem_gnt,
   input  logic        i_mem_rvalid,
   input  logic [31:0] i_mem_rdata
);

   localparam int CW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

   state_t        state_q, state_d;
   logic          we_q;
   logic [2:0]    f3_q;
   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    err_q, err_d;
   logic [31:0]   ld_data_q, ld_data_d;
   logic          accept_s;
   logic [31:0]   extract_s;

   assign accept_s = i_valid && (state_q == ST_IDLE);

   lsu_extract u_extract (
      .rdata_i  (i_mem_rdata),
      .off_i    (addr_q[1:0]),
      .funct3_i (f3_q),
      .data_o   (extract_s)
   );

   // State, counter and response registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         err_q     <= ERR_NONE;
         ld_data_q <= 32'h0000_0000;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         ld_data_q <= ld_data_d;
      end
   end

   // Operation capture; only written on accept so later input changes are ignored
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         we_q    <= 1'b0;
         f3_q    <= 3'b000;
         addr_q  <= 32'h0000_0000;
         wdata_q <= 32'h0000_0000;
      end else if (accept_s) begin
         we_q    <= i_we;
         f3_q    <= i_funct3;
         addr_q  <= i_addr;
         wdata_q <= i_wdata;
      end else begin
         we_q    <= we_q;
         f3_q    <= f3_q;
         addr_q  <= addr_q;
         wdata_q <= wdata_q;
      end
   end

   // Next-state logic; kill only matters while the request is still outstanding
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      ld_data_d = ld_data_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               err_d     = ERR_NONE;
               ld_data_d = 32'h0000_0000;
               cnt_d     = '0;
               if (f3_illegal(i_we, i_funct3)) begin
                  state_d = ST_RESP;
                  err_d   = ERR_ILLEGAL;
               end else if (misaligned(i_funct3, i_addr[1:0])) begin
                  state_d = ST_RESP;
                  err_d   = ERR_MISALIGN;
               end else begin
                  state_d = ST_REQ;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (i_kill) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (i_mem_gnt) begin
               cnt_d = '0;
               if (we_q) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_WAIT;
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_RESP;
               err_d   = ERR_TIMEOUT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_WAIT: begin
            if (i_mem_rvalid) begin
               state_d   = ST_RESP;
               ld_data_d = extract_s;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_RESP;
               err_d   = ERR_TIMEOUT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_RESP: begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            err_d     = ERR_NONE;
            ld_data_d = 32'h0000_0000;
         end
         default: begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            err_d     = ERR_NONE;
            ld_data_d = 32'h0000_0000;
         end
      endcase
   end

   // Outputs decoded from registered state only
   always_comb begin
      o_ready     = (state_q == ST_IDLE);
      o_done      = (state_q == ST_RESP);
      o_mem_req   = (state_q == ST_REQ);
      if (state_q == ST_RESP) begin
         o_err     = err_q;
         o_ld_data = ld_data_q;
      end else begin
         o_err     = ERR_NONE;
         o_ld_data = 32'h0000_0000;
      end
      if (state_q == ST_REQ) begin
         o_mem_we    = we_q;
         o_mem_addr  = {addr_q[31:2], 2'b00};
         o_mem_wdata = wdata_gen(f3_q, wdata_q);
         o_mem_be    = be_gen(we_q, f3_q, addr_q[1:0]);
      end else begin
         o_mem_we    = 1'b0;
         o_mem_addr  = 32'h0000_0000;
         o_mem_wdata = 32'h0000_0000;
         o_mem_be    = 4'b0000;
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard-driven bench for lsu_ctrl with a short memory timeout.
module tb_lsu_ctrl;

   logic        i_clk = 1'b0;
   logic        i_rst_n, i_valid, i_we, i_kill;
   logic [2:0]  i_funct3;
   logic [31:0] i_addr, i_wdata, i_mem_rdata;
   logic        i_mem_gnt, i_mem_rvalid;
   logic        o_ready, o_done, o_mem_req, o_mem_we;
   logic [31:0] o_ld_data, o_mem_addr, o_mem_wdata;
   logic [1:0]  o_err;
   logic [3:0]  o_mem_be;

   always #5 i_clk = ~i_clk;

   lsu_ctrl #(.MEM_TIMEOUT(4)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_we(i_we),
      .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata), .i_kill(i_kill),
      .o_ready(o_ready), .o_done(o_done), .o_ld_data(o_ld_data), .o_err(o_err),
      .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
      .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be), .i_mem_gnt(i_mem_gnt),
      .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
   );

   typedef struct {
      int          lat;
      logic [1:0]  err;
      logic [31:0] data;
   } exp_t;

   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   t_acc = 0;

   task automatic tick();
      @(posedge i_clk);
      #1;
      cyc++;
   endtask

   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
      i_valid = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wdata;
      t_acc = cyc;
      tick();
      i_valid = 1'b0; i_we = ~we; i_funct3 = 3'b111; i_addr = 32'hFFFF_FFFF; i_wdata = 32'h0;
   endtask

   task automatic wait_done(input int budget, output logic seen, output int lat,
                            output logic [1:0] err, output logic [31:0] data);
      seen = 1'b0; lat = 0; err = 2'b00; data = 32'h0;
      for (int i = 0; i < budget && !seen; i++) begin
         if (o_done === 1'b1) begin
            seen = 1'b1; lat = cyc - t_acc; err = o_err; data = o_ld_data;
         end else begin
            tick();
         end
      end
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0; i_valid = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h0;
      i_wdata = 32'h0; i_kill = 1'b0; i_mem_gnt = 1'b1; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h0;
      repeat (3) tick();
      checks++;
      if (o_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready: got %b expected 1", o_ready);
      end
      checks++;
      if ({o_done, o_err, o_ld_data, o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata} !== 105'h0) begin
         errors++; $display("FAIL reset_outputs: done=%b err=%b req=%b be=%b addr=%h expected all 0",
                            o_done, o_err, o_mem_req, o_mem_be, o_mem_addr);
      end
      i_valid = 1'b0; i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0;
      tick();
      i_rst_n = 1'b1;
      tick();
      checks++;
      if ({o_ready, o_done, o_mem_req} !== 3'b100) begin
         errors++; $display("FAIL reset_release: ready/done/req=%b expected 100", {o_ready, o_done, o_mem_req});
      end
   endtask

   task automatic test_store_sw();
      logic seen; int lat; logic [1:0] err; logic [31:0] data; exp_t e;
      sb_q.push_back('{2, 2'b00, 32'h0});
      issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
      checks++;
      if ({o_ready, o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata} !==
          {1'b0, 1'b1, 1'b1, 4'b1111, 32'h100, 32'hDEADBEEF}) begin
         errors++; $display("FAIL sw_req: req=%b we=%b be=%b addr=%h wdata=%h expected 1 1 1111 00000100 deadbeef",
                            o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata);
      end
      i_mem_gnt = 1'b1;
      wait_done(20, seen, lat, err, data);
      i_mem_gnt = 1'b0;
      e = sb_q.pop_front();
      checks++;
      if (!seen || lat !== e.lat || err !== e.err || data !== e.data) begin
         errors++; $display("FAIL sw_resp: seen=%b lat=%0d err=%b data=%h expected lat=%0d err=%b data=%h",
                            seen, lat, err, data, e.lat, e.err, e.data);
      end
      tick();
      checks++;
      if ({o_done, o_ready} !== 2'b01) begin
         errors++; $display("FAIL sw_pulse: done/ready=%b expected 01", {o_done, o_ready});
      end
   endtask

   typedef struct packed {
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] mwdata;
      logic [1:0]  dly;
   } st_row_t;

   task automatic test_store_lanes();
      logic seen; int lat; logic [1:0] err; logic [31:0] data; exp_t e;
      st_row_t rows [4];
      rows[0] = '{3'b001, 32'h102, 32'h1234ABCD, 4'b1100, 32'hABCDABCD, 2'd0};
      rows[1] = '{3'b000, 32'h103, 32'h000000EF, 4'b1000, 32'hEFEFEFEF, 2'd2};
      rows[2] = '{3'b000, 32'h001, 32'h12345678, 4'b0010, 32'h78787878, 2'd1};
      rows[3] = '{3'b001, 32'h3FC, 32'h5555AAAA, 4'b0011, 32'hAAAAAAAA, 2'd3};
      for (int r = 0; r < 4; r++) begin
         sb_q.push_back('{2 + int'(rows[r].dly), 2'b00, 32'h0});
         issue(1'b1, rows[r].f3, rows[r].addr, rows[r].wdata);
         for (int k = 0; k <= int'(rows[r].dly); k++) begin
            checks++;
            if ({o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata} !==
                {1'b1, 1'b1, rows[r].be, rows[r].addr[31:2], 2'b00, rows[r].mwdata}) begin
               errors++; $display("FAIL store_lane%0d_c%0d: req=%b be=%b addr=%h wdata=%h expected be=%b addr=%h wdata=%h",
                                  r, k, o_mem_req, o_mem_be, o_mem_addr, o_mem_wdata,
                                  rows[r].be, {rows[r].addr[31:2], 2'b00}, rows[r].mwdata);
            end
            if (k < int'(rows[r].dly)) begin
               i_valid = 1'b1; i_we = 1'b0; i_addr = 32'hFFFF_FFF0;
               tick();
            end
         end
         i_valid = 1'b0; i_mem_gnt = 1'b1;
         wait_done(20, seen, lat, err, data);
         i_mem_gnt = 1'b0;
         e = sb_q.pop_front();
         checks++;
         if (!seen || lat !== e.lat || err !== e.err || data !== e.data) begin
            errors++; $display("FAIL store_lane%0d_resp: seen=%b lat=%0d err=%b expected lat=%0d err=%b",
                               r, seen, lat, err, e.lat, e.err);
         end
         tick();
      end
   endtask

   task automatic test_loads();
      logic seen; int lat; logic [1:0] err; logic [31:0] data; exp_t e;
      logic [2:0]  f3s   [7] = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b101, 3'b101, 3'b010};
      logic [31:0] addrs [7] = '{32'h203, 32'h203, 32'h200, 32'h202, 32'h202, 32'h200, 32'h204};
      logic [31:0] exps  [7] = '{32'hFFFFFF80, 32'h00000080, 32'h0000007F, 32'hFFFF80FF,
                                 32'h000080FF, 32'h0000FF7F, 32'h80FFFF7F};
      for (int r = 0; r < 7; r++) begin
         sb_q.push_back('{3, 2'b00, exps[r]});
         issue(1'b0, f3s[r], addrs[r], 32'h0);
         checks++;
         if ({o_mem_req, o_mem_we, o_mem_be, o_mem_addr} !== {1'b1, 1'b0, 4'b0000, addrs[r][31:2], 2'b00}) begin
            errors++; $display("FAIL load%0d_req: req=%b we=%b be=%b addr=%h expected 1 0 0000 %h",
                               r, o_mem_req, o_mem_we, o_mem_be, o_mem_addr, {addrs[r][31:2], 2'b00});
         end
         i_mem_gnt = 1'b1; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h5A5A5A5A;
         tick();
         i_mem_gnt = 1'b0; i_mem_rdata = 32'h80FFFF7F;
         wait_done(20, seen, lat, err, data);
         i_mem_rvalid = 1'b0;
         e = sb_q.pop_front();
         checks++;
         if (!seen || lat !== e.lat || err !== e.err || data !== e.data) begin
            errors++; $display("FAIL load%0d_resp: seen=%b lat=%0d err=%b data=%h expected lat=%0d err=%b data=%h",
                               r, seen, lat, err, data, e.lat, e.err, e.data);
         end
         tick();
         checks++;
         if ({o_done, o_err, o_ld_data} !== 35'h0) begin
            errors++; $display("FAIL load%0d_idle: done=%b err=%b data=%h expected all 0", r, o_done, o_err, o_ld_data);
         end
      end
   endtask

   task automatic test_errors();
      logic seen; int lat; logic [1:0] err; logic [31:0] data; exp_t e;
      logic        wes   [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [2:0]  f3s   [7] = '{3'b010, 3'b011, 3'b100, 3'b001, 3'b010, 3'b011, 3'b111};
      logic [31:0] addrs [7] = '{32'h101, 32'h100, 32'h100, 32'h101, 32'h102, 32'h003, 32'h000};
      logic [1:0]  errs  [7] = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10};
      for (int r = 0; r < 7; r++) begin
         sb_q.push_back('{1, errs[r], 32'h0});
         issue(wes[r], f3s[r], addrs[r], 32'hFFFFFFFF);
         checks++;
         if (o_mem_req !== 1'b0) begin
            errors++; $display("FAIL err%0d_noreq: req=%b expected 0", r, o_mem_req);
         end
         wait_done(20, seen, lat, err, data);
         e = sb_q.pop_front();
         checks++;
         if (!seen || lat !== e.lat || err !== e.err || data !== e.data) begin
            errors++; $display("FAIL err%0d_resp: seen=%b lat=%0d err=%b expected lat=%0d err=%b",
                               r, seen, lat, err, e.lat, e.err);
         end
         tick();
      end
   endtask

   task automatic test_timeout();
      logic seen; int lat; logic [1:0] err; logic [31:0] data; exp_t e; int req_cycles;
      sb_q.push_back('{5, 2'b11, 32'h0});
      issue(1'b0, 3'b010, 32'h300, 32'h0);
      req_cycles = 0;
      for (int i = 0; i < 12 && o_done !== 1'b1; i++) begin
         if (o_mem_req === 1'b1) req_cycles++;
         tick();
      end
      checks++;
      if (req_cycles !== 4 || o_mem_req !== 1'b0) begin
         errors++; $display("FAIL tmo_req_cycles: req cycles=%0d req_now=%b expected 4 and 0", req_cycles, o_mem_req);
      end
      wait_done(20, seen, lat, err, data);
      e = sb_q.pop_front();
      checks++;
      if (!seen || lat !== e.lat || err !== e.err) begin
         errors++; $display("FAIL tmo_req_resp: seen=%b lat=%0d err=%b expected lat=%0d err=%b", seen, lat, err, e.lat, e.err);
      end
      tick();
      sb_q.push_back('{6, 2'b11, 32'h0});
      issue(1'b0, 3'b010, 32'h304, 32'h0);
      i_mem_gnt = 1'b1;
      tick();
      i_mem_gnt = 1'b0;
      wait_done(20, seen, lat, err, data);
      e = sb_q.pop_front();
      checks++;
      if (!seen || lat !== e.lat || err !== e.err) begin
         errors++; $display("FAIL tmo_wait_resp: seen=%b lat=%0d err=%b expected lat=%0d err=%b", seen, lat, err, e.lat, e.err);
      end
      tick();
      sb_q.push_back('{5, 2'b00, 32'h0});
      issue(1'b1, 3'b010, 32'h308, 32'h1);
      repeat (3) tick();
      i_mem_gnt = 1'b1;
      wait_done(20, seen, lat, err, data);
      i_mem_gnt = 1'b0;
      e = sb_q.pop_front();
      checks++;
      if (!seen || lat !== e.lat || err !== e.err) begin
         errors++; $display("FAIL tmo_last_gnt: seen=%b lat=%0d err=%b expected lat=%0d err=%b", seen, lat, err, e.lat, e.err);
      end
      tick();
   endtask

   task automatic test_kill();
      logic seen; int lat; logic [1:0] err; logic [31:0] data; exp_t e; logic any_done;
      for (int v = 0; v < 2; v++) begin
         issue(v == 0, 3'b010, 32'h400, 32'h5);
         i_kill = 1'b1; i_mem_gnt = (v == 1);
         tick();
         i_kill = 1'b0; i_mem_gnt = 1'b0; i_mem_rvalid = 1'b1;
         checks++;
         if ({o_ready, o_mem_req, o_done} !== 3'b100) begin
            errors++; $display("FAIL kill%0d_idle: ready/req/done=%b expected 100", v, {o_ready, o_mem_req, o_done});
         end
         any_done = 1'b0;
         for (int i = 0; i < 6; i++) begin
            if (o_done === 1'b1 || o_mem_req === 1'b1) any_done = 1'b1;
            tick();
         end
         i_mem_rvalid = 1'b0;
         checks++;
         if (any_done !== 1'b0) begin
            errors++; $display("FAIL kill%0d_quiet: activity=%b expected 0", v, any_done);
         end
      end
      sb_q.push_back('{4, 2'b00, 32'hCAFEF00D});
      issue(1'b0, 3'b010, 32'h404, 32'h0);
      i_mem_gnt = 1'b1;
      tick();
      i_mem_gnt = 1'b0; i_kill = 1'b1;
      tick();
      i_kill = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'hCAFEF00D;
      wait_done(20, seen, lat, err, data);
      i_mem_rvalid = 1'b0;
      e = sb_q.pop_front();
      checks++;
      if (!seen || lat !== e.lat || err !== e.err || data !== e.data) begin
         errors++; $display("FAIL kill_wait_drain: seen=%b lat=%0d err=%b data=%h expected lat=%0d err=%b data=%h",
                            seen, lat, err, data, e.lat, e.err, e.data);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      logic any_act;
      issue(1'b0, 3'b010, 32'h500, 32'h0);
      i_mem_gnt = 1'b1;
      tick();
      i_mem_gnt = 1'b0;
      #2 i_rst_n = 1'b0;
      #1;
      checks++;
      if ({o_ready, o_done, o_mem_req, o_err, o_ld_data, o_mem_addr, o_mem_be} !== {1'b1, 72'h0}) begin
         errors++; $display("FAIL rst_mid_outputs: ready=%b done=%b req=%b err=%b expected 1 0 0 00",
                            o_ready, o_done, o_mem_req, o_err);
      end
      tick();
      i_rst_n = 1'b1; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h11223344;
      any_act = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (o_done === 1'b1 || o_mem_req === 1'b1 || o_ready !== 1'b1) any_act = 1'b1;
      end
      i_mem_rvalid = 1'b0;
      checks++;
      if (any_act !== 1'b0) begin
         errors++; $display("FAIL rst_mid_quiet: activity=%b expected 0", any_act);
      end
   endtask

   task automatic test_back_to_back();
      logic seen; int lat; logic [1:0] err; logic [31:0] data; exp_t e;
      i_mem_gnt = 1'b1;
      for (int j = 0; j < 3; j++) sb_q.push_back('{2, 2'b00, 32'h0});
      for (int j = 0; j < 3; j++) begin
         issue(1'b1, 3'b010, 32'h600 + 32'(4 * j), 32'(j));
         wait_done(20, seen, lat, err, data);
         e = sb_q.pop_front();
         checks++;
         if (!seen || lat !== e.lat || err !== e.err) begin
            errors++; $display("FAIL b2b%0d: seen=%b lat=%0d err=%b expected lat=%0d err=%b", j, seen, lat, err, e.lat, e.err);
         end
         tick();
      end
      i_mem_gnt = 1'b0;
      checks++;
      if (sb_q.size() !== 0) begin
         errors++; $display("FAIL sb_empty: %0d entries left expected 0", sb_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_store_sw();
      test_store_lanes();
      test_loads();
      test_errors();
      test_timeout();
      test_kill();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
